// File: rtl/alu_sequencer.sv
// Three-state sequencer that drives an external 4-bit ALU from a 4x4 register file.
// Optional macro ALU_SEQ_PERF_EN builds a saturating retired-instruction counter on op_count.
module alu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [11:0] instr,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [1:0]  alu_sel,
   input  logic [3:0]  alu_out,
   input  logic        alu_carry,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [3:0]  res_data,
   output logic        carry_flag,
   output logic        zero_flag,
   output logic        busy,
   output logic [7:0]  op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, EMIT} state_t;

   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_OUT = 2'b10;

   state_t      state;
   logic [11:0] ir;
   logic [3:0]  rf [4];

   logic [1:0]  op;
   logic [1:0]  rd;
   logic [1:0]  rs1;
   logic        unused_sel;

   assign op  = ir[11:10];
   assign rd  = ir[7:6];
   assign rs1 = ir[5:4];
   // The ALU select is captured straight from instr at accept time.
   assign unused_sel = ^ir[9:8];

   assign instr_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   // ALU operands are registered at accept: the register file cannot change
   // between accept and EXEC, so they equal the pre-write EXEC values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ir         <= '0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= EXEC;
                  if (instr[11:10] == OP_ALU) begin
                     alu_a   <= rf[instr[5:4]];
                     alu_b   <= rf[instr[3:2]];
                     alu_sel <= instr[9:8];
                  end
               end
            end
            EXEC: begin
               alu_a   <= '0;
               alu_b   <= '0;
               alu_sel <= '0;
               state   <= IDLE;
               case (op)
                  OP_ALU: begin
                     rf[rd]     <= alu_out;
                     carry_flag <= alu_carry;
                     zero_flag  <= alu_zero;
                  end
                  OP_LDI: rf[rd] <= ir[3:0];
                  OP_OUT: begin
                     res_data  <= rf[rs1];
                     res_valid <= 1'b1;
                     state     <= EMIT;
                  end
                  default: ;
               endcase
            end
            EMIT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_PERF_EN
   logic [7:0] count;
   logic       retire;

   assign retire = ((state == EXEC) && (op != OP_OUT)) || ((state == EMIT) && res_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (retire && (count != 8'hFF))
         count <= count + 8'd1;
   end

   assign op_count = count;
`else
   assign op_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: an ALU model closes the loop, OUT results go
// through an expected-value queue checked by an independent monitor process.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [11:0] instr = '0;
   logic [3:0]  alu_a, alu_b;
   logic [1:0]  alu_sel;
   logic [3:0]  alu_out;
   logic        alu_carry, alu_zero;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [3:0]  res_data;
   logic        carry_flag, zero_flag, busy;
   logic [7:0]  op_count;

`ifdef ALU_SEQ_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int exp_ops = 0;
   logic [3:0] exp_q [$];

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .carry_flag(carry_flag), .zero_flag(zero_flag), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // External combinational ALU
   logic [4:0] alu_r;
   always_comb begin
      alu_r = '0;
      case (alu_sel)
         2'd0: alu_r = {1'b0, alu_a & alu_b};
         2'd1: alu_r = {1'b0, alu_a | alu_b};
         2'd2: alu_r = {1'b0, alu_a ^ alu_b};
         default: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      endcase
   end
   assign alu_out   = alu_r[3:0];
   assign alu_carry = alu_r[4];
   assign alu_zero  = (alu_r[3:0] == 4'h0);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [11:0] f_ldi(input logic [1:0] rd, input logic [3:0] imm);
      return {2'b01, 2'b00, rd, 2'b00, imm};
   endfunction
   function automatic logic [11:0] f_alu(input logic [1:0] sel, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
      return {2'b00, sel, rd, rs1, rs2, 2'b00};
   endfunction
   function automatic logic [11:0] f_out(input logic [1:0] rs);
      return {2'b10, 2'b00, 2'b00, rs, 4'h0};
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge (DUT in EXEC).
   task automatic issue(input logic [11:0] w);
      int n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         check("issue_timeout", {31'd0, instr_ready}, 32'd1);
         return;
      end
      instr = w;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      exp_ops++;
      $display("issue instr=0x%03h", w);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic out_reg(input logic [1:0] rs, input logic [3:0] expv);
      exp_q.push_back(expv);
      issue(f_out(rs));
      wait_idle();
   endtask

   // Monitor: pops one expected result per completed result handshake.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL res_unexpected got=0x%0h expected=none", res_data);
            end else begin
               e = exp_q.pop_front();
               $display("result res_data=0x%0h expected=0x%0h", res_data, e);
               check("res_data", {28'd0, res_data}, {28'd0, e});
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
      check("rst_op_count", {24'd0, op_count}, 32'd0);
      check("rst_alu", {22'd0, alu_sel, alu_a, alu_b}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", {31'd0, instr_ready}, 32'd1);

      // LDI/LDI/ADD with carry-out and zero result
      issue(f_ldi(2'd1, 4'hA));
      check("alu_zero_in_ldi", {22'd0, alu_sel, alu_a, alu_b}, 32'd0);
      check("busy_exec", {31'd0, busy}, 32'd1);
      issue(f_ldi(2'd2, 4'h6));
      issue(f_alu(2'd3, 2'd3, 2'd1, 2'd2));
      check("alu_drive_add", {22'd0, alu_sel, alu_a, alu_b}, {22'd0, 2'd3, 4'hA, 4'h6});
      @(negedge clk);
      check("add_flags", {30'd0, carry_flag, zero_flag}, 32'd3);
      out_reg(2'd3, 4'h0);

      // LDI preserves flags; ALU outputs idle at zero
      issue(f_ldi(2'd1, 4'h5));
      @(negedge clk);
      check("ldi_keeps_flags", {30'd0, carry_flag, zero_flag}, 32'd3);
      check("alu_zero_idle", {22'd0, alu_sel, alu_a, alu_b}, 32'd0);

      // Logic ops
      issue(f_ldi(2'd0, 4'hC));
      issue(f_ldi(2'd1, 4'hA));
      issue(f_alu(2'd0, 2'd2, 2'd0, 2'd1));
      @(negedge clk);
      check("and_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
      issue(f_alu(2'd1, 2'd3, 2'd0, 2'd1));
      @(negedge clk);
      check("or_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
      out_reg(2'd2, 4'h8);
      issue(f_alu(2'd2, 2'd0, 2'd0, 2'd0));
      @(negedge clk);
      check("xor_flags", {30'd0, carry_flag, zero_flag}, 32'd1);
      out_reg(2'd0, 4'h0);

      // OUT with back-pressure
      res_ready = 1'b0;
      exp_q.push_back(4'hE);
      issue(f_out(2'd3));
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("emit_valid_held", {31'd0, res_valid}, 32'd1);
         check("emit_data_stable", {28'd0, res_data}, 32'hE);
         check("emit_ready_low", {31'd0, instr_ready}, 32'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("emit_done_ready", {31'd0, instr_ready}, 32'd1);
      check("emit_done_valid", {31'd0, res_valid}, 32'd0);

      // Back-to-back NOPs with instr_valid held high
      instr = 12'hC00;
      instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("nop_accept_pattern", {31'd0, instr_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      exp_ops += 4;
      $display("nop burst done op_count=%0d", op_count);
      check("op_count", {24'd0, op_count}, PERF_EN ? exp_ops : 32'd0);

      // Reset during EMIT
      res_ready = 1'b0;
      issue(f_out(2'd3));
      @(negedge clk);
      check("pre_reset_valid", {31'd0, res_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_drop_valid", {31'd0, res_valid}, 32'd0);
      check("async_idle", {30'd0, busy, instr_ready}, 32'd1);
      check("async_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
      check("async_op_count", {24'd0, op_count}, 32'd0);
      exp_ops = 0;
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      check("ready_after_rst2", {31'd0, instr_ready}, 32'd1);
      out_reg(2'd3, 4'h0);
      out_reg(2'd1, 4'h0);
      @(negedge clk);
      check("op_count_final", {24'd0, op_count}, PERF_EN ? exp_ops : 32'd0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: instr_valid  input  1 / instr_ready  output  1 / instr  input  12  instruction handshake.
REQ-004 SHALL have: alu_a, alu_b  output  4 / alu_sel  output  2  operands and op to the external combinational 4-bit ALU.
REQ-005 SHALL have: alu_out  input  4 / alu_carry  input  1 / alu_zero  input  1  ALU results.
REQ-006 SHALL have: res_valid  output  1 / res_ready  input  1 / res_data  output  4  result handshake.
REQ-007 SHALL have: carry_flag, zero_flag  output  1  flags; busy  output  1  high when not IDLE; op_count  output  8  retired-instruction count.

Function
REQ-008 SHALL decode instr[11:10] as: 00 ALU, 01 LDI, 10 OUT, 11 NOP.
REQ-009 ALU fields SHALL be: [9:8] sel (00 AND, 01 OR, 10 XOR, 11 ADD), [7:6] rd, [5:4] rs1, [3:2] rs2; [1:0] ignored.
REQ-010 LDI SHALL write imm = instr[3:0] to R[instr[7:6]]; OUT SHALL emit R[instr[5:4]]; NOP SHALL only retire.
REQ-011 SHALL hold a 4x4-bit register file R0..R3 and one 12-bit instruction latch.
REQ-012 FSM states SHALL be IDLE, EXEC, EMIT; instr_ready = 1 only in IDLE.
REQ-013 IDLE: on instr_valid (ready high) latch instr, go EXEC; otherwise stay.
REQ-014 EXEC (exactly one cycle): alu_a = R[rs1], alu_b = R[rs2], alu_sel = sel; for ALU, on the EXEC clock edge write alu_out to R[rd], alu_carry to carry_flag, alu_zero to zero_flag; next IDLE.
REQ-015 EXEC for LDI SHALL write imm and go IDLE; for NOP go IDLE; for OUT capture R[rs1] into res_data and go EMIT.
REQ-016 alu_a, alu_b, alu_sel SHALL be 0 outside EXEC and in EXEC of non-ALU instructions.
REQ-017 EMIT: res_valid = 1 and res_data stable until res_ready sampled high; then go IDLE.
REQ-018 Flags SHALL change only on ALU instructions; LDI, OUT, NOP preserve them.
REQ-019 Operand reads SHALL use register values before the EXEC write (rd == rs1 == rs2 legal).
REQ-020 Latency: ALU/LDI/NOP accepted at edge N complete at edge N+1, instr_ready high again after edge N+1; OUT result valid after edge N+1.
REQ-021 res_ready while res_valid = 0 SHALL be ignored; instr_valid outside IDLE SHALL be ignored (no accept).
REQ-022 ADD overflow SHALL wrap to 4 bits with carry_flag = carry out.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, R0..R3 = 0, instruction latch = 0, flags = 0, res_data = 0, res_valid = 0, op_count = 0, busy = 0.
REQ-024 Reset during EXEC or EMIT SHALL abort the instruction without register or flag write and drop res_valid asynchronously.
REQ-025 After reset release instr_ready SHALL be 1 on the first clock.

Configuration
REQ-026 Macro ALU_SEQ_PERF_EN: when defined, op_count SHALL increment by 1 per retired instruction (leaving EXEC to IDLE, or EMIT handshake), saturating at 255.
REQ-027 Without ALU_SEQ_PERF_EN, op_count SHALL be tied to 0 and no counter register SHALL be built.

Verification
REQ-028 Reset then LDI R1=0xA, LDI R2=0x6, ADD R3=R1+R2 -> R3 = 0x0, carry_flag = 1, zero_flag = 1.
REQ-029 LDI R0=0xC, R1=0xA; AND R2, OR R3 -> R2 = 0x8, R3 = 0xE, flags 0/0; XOR R0=R0^R0 -> R0 = 0, zero_flag = 1.
REQ-030 OUT R3 with res_ready low for 3 cycles -> res_valid held, res_data = 0xE stable, instr_ready low; res_ready high -> IDLE next cycle.
REQ-031 instr_valid held high continuously with 4 NOPs -> one accept every 2 cycles, op_count = 4 (PERF_EN) or 0 (not defined).
REQ-032 rst_n asserted during EMIT -> res_valid = 0 immediately, registers and flags = 0, instr_ready = 1 after release.
REQ-033 LDI R1 after ADD setting carry -> carry_flag stays 1; ALU outputs zero in IDLE.
